uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_rx_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared constants and FSM state encoding for the UART receiver.
package uart_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 10;
    localparam int unsigned DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// Bit-period counter: free-runs unless cleared, flags the half-bit and full-bit terminal counts.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear,
    output logic half_done,
    output logic full_done
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign half_done = (cnt == HALF_LAST);
    assign full_done = (cnt == FULL_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// UART receiver: synchronizer, start/data/stop/break FSM and a one-deep
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    state_t               state;
    logic                 rx_m, rx_s, rx_d;
    logic [1:0]           settle;
    logic                 armed;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic                 half_done, full_done;
    logic                 timer_clear;
    logic                 stop_ok;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .half_done (half_done),
        .full_done (full_done)
    );

    always_comb begin
        timer_clear = 1'b0;
        case (state)
            IDLE, BREAK: timer_clear = 1'b1;
            START:       timer_clear = half_done;
            DATA, STOP:  timer_clear = full_done;
            default:     timer_clear = 1'b1;
        endcase
    end

    assign stop_ok = (state == STOP) && full_done && rx_s;
    assign busy    = (state != IDLE);

    // The reset value of the synchronizer is artificial; only arm edge detection
    // once a genuine high has travelled through, so a line held low is ignored.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_d   <= 1'b1;
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            rx_m   <= rx_in;
            rx_s   <= rx_m;
            rx_d   <= rx_s;
            settle <= {settle[0], 1'b1};
            if (settle[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && rx_d && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (half_done) begin
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (full_done) begin
                        shift[idx] <= rx_s;
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (full_done) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (stop_ok) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
